// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared state encoding and enable qualification for the strobe decoder
package dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    function automatic logic en_ok(input logic g1, input logic g2a, input logic g2b);
        return g1 & ~g2a & ~g2b;
    endfunction

endpackage

// File: rtl/onehot_dec_n.sv
// rtl/onehot_dec_n.sv - combinational SEL_W-to-2^SEL_W active-low one-hot decode
module onehot_dec_n #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [(1<<SEL_W)-1:0] dec_n
);

    always_comb begin
        dec_n      = '1;
        dec_n[sel] = 1'b0;
    end

endmodule

// File: rtl/latched_decoder_strobe.sv
// rtl/latched_decoder_strobe.sv - latched N-to-2^N decoder with timed active-low strobes
// Optional one-entry request buffer: LATCHED_DECODER_PENDING_EN
module latched_decoder_strobe
    import dec_pkg::*;
#(
    parameter int SEL_W     = 3,
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SEL_W-1:0]        s,
    input  logic                    g1,
    input  logic                    g2a,
    input  logic                    g2b,
    input  logic                    req_valid,
    output logic                    req_ready,
    output logic [(1<<SEL_W)-1:0]   f,
    output logic                    busy,
    output logic                    rejected
);

    localparam int OUT_N   = 1 << SEL_W;
    localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [OUT_N-1:0]   f_d;
    logic [OUT_N-1:0]   dec_n;
    logic               rej_d;
    logic               accept;
    logic               en_now;
    logic               exit_now;
    logic               launch;
    logic [SEL_W-1:0]   launch_sel;
    logic               launch_en;

`ifdef LATCHED_DECODER_PENDING_EN
    logic               pend_v, pend_v_d;
    logic [SEL_W-1:0]   pend_sel, pend_sel_d;
    logic               pend_en, pend_en_d;

    assign req_ready = (state == ST_IDLE) | ~pend_v;
`else
    assign req_ready = (state == ST_IDLE);
`endif

    assign busy   = (state != ST_IDLE);
    assign accept = req_valid & req_ready;
    assign en_now = en_ok(g1, g2a, g2b);

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        sel_d      = sel_q;
        rej_d      = 1'b0;
        exit_now   = 1'b0;
        launch     = 1'b0;
        launch_sel = s;
        launch_en  = en_now;
`ifdef LATCHED_DECODER_PENDING_EN
        pend_v_d   = pend_v;
        pend_sel_d = pend_sel;
        pend_en_d  = pend_en;
`endif

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    launch = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cnt == '0) begin
                    if (GAP_CYC > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        exit_now = 1'b1;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    exit_now = 1'b1;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (exit_now) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end

`ifdef LATCHED_DECODER_PENDING_EN
        // On exit the buffered request (or one arriving on that very edge) starts with no idle cycle
        if (exit_now) begin
            if (pend_v) begin
                launch     = 1'b1;
                launch_sel = pend_sel;
                launch_en  = pend_en;
                pend_v_d   = 1'b0;
            end else if (accept) begin
                launch = 1'b1;
            end
        end else if (busy && accept) begin
            pend_v_d   = 1'b1;
            pend_sel_d = s;
            pend_en_d  = en_now;
        end
`endif

        if (launch) begin
            if (launch_en) begin
                state_d = ST_ACTIVE;
                cnt_d   = PULSE_LD;
                sel_d   = launch_sel;
            end else begin
                rej_d = 1'b1;
            end
        end

        // Decoding the next select lets f change on the accept edge itself
        f_d = (state_d == ST_ACTIVE) ? dec_n : '1;
    end

    onehot_dec_n #(
        .SEL_W (SEL_W)
    ) u_dec (
        .sel   (sel_d),
        .dec_n (dec_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sel_q    <= '0;
            f        <= '1;
            rejected <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            sel_q    <= sel_d;
            f        <= f_d;
            rejected <= rej_d;
        end
    end

`ifdef LATCHED_DECODER_PENDING_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v   <= 1'b0;
            pend_sel <= '0;
            pend_en  <= 1'b0;
        end else begin
            pend_v   <= pend_v_d;
            pend_sel <= pend_sel_d;
            pend_en  <= pend_en_d;
        end
    end
`endif

endmodule

// File: tb/tb_latched_decoder_strobe.sv
// tb/tb_latched_decoder_strobe.sv - randomized self-checking bench against a pulse-window model
module tb_latched_decoder_strobe;

    localparam int SEL_W = 3;
    localparam int P     = 2;
    localparam int G     = 1;

    logic       clk;
    logic       rst_n;
    logic [2:0] s;
    logic       g1, g2a, g2b;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] f;
    logic       busy;
    logic       rejected;

    int total = 0;
    int bad   = 0;

    // Model: edge index, edge at which the current pulse window closes, edge the block is free again
    int         c      = 0;
    int         lo_end = 0;
    int         end_e  = 0;
    logic [2:0] sel_m  = '0;
    bit         rej_m  = 1'b0;
    bit         rdy_m  = 1'b1;
    bit         pv     = 1'b0;
    logic [2:0] ps     = '0;
    bit         pe     = 1'b0;

    latched_decoder_strobe #(
        .SEL_W     (SEL_W),
        .PULSE_CYC (P),
        .GAP_CYC   (G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (s),
        .g1        (g1),
        .g2a       (g2a),
        .g2b       (g2b),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .f         (f),
        .busy      (busy),
        .rejected  (rejected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, c, obs, exp);
        end
    endtask

    task automatic start_or_reject(input logic [2:0] sv, input bit en);
        if (en) begin
            sel_m  = sv;
            lo_end = c + P;
            end_e  = c + P + G;
        end else begin
            rej_m = 1'b1;
        end
    endtask

    task automatic model_edge(input logic v, input logic [2:0] sv, input bit en);
        bit acc;
        bit was_idle;
        acc      = v & rdy_m;
        c++;
        rej_m    = 1'b0;
        was_idle = (c - 1 >= end_e);
        if (was_idle) begin
            if (acc) start_or_reject(sv, en);
        end else if (c == end_e) begin
`ifdef LATCHED_DECODER_PENDING_EN
            if (pv) begin
                pv = 1'b0;
                start_or_reject(ps, pe);
            end else if (acc) begin
                start_or_reject(sv, en);
            end
`endif
        end else begin
`ifdef LATCHED_DECODER_PENDING_EN
            if (acc) begin
                pv = 1'b1;
                ps = sv;
                pe = en;
            end
`endif
        end
`ifdef LATCHED_DECODER_PENDING_EN
        rdy_m = (c >= end_e) || !pv;
`else
        rdy_m = (c >= end_e);
`endif
    endtask

    task automatic check_outputs();
        logic [7:0] f_exp;
        f_exp = (c < lo_end) ? ~(8'b1 << sel_m) : 8'hFF;
        check("f", {24'b0, f}, {24'b0, f_exp});
        check("busy", {31'b0, busy}, {31'b0, (c < end_e)});
        check("req_ready", {31'b0, req_ready}, {31'b0, rdy_m});
        check("rejected", {31'b0, rejected}, {31'b0, rej_m});
    endtask

    task automatic cycle(input logic v, input logic [2:0] sv, input logic a, input logic b, input logic cc);
        req_valid = v;
        s         = sv;
        g1        = a;
        g2a       = b;
        g2b       = cc;
        @(posedge clk);
        model_edge(v, sv, a & ~b & ~cc);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_f", {24'b0, f}, 32'h0000_00FF);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rejected", {31'b0, rejected}, 32'd0);
        lo_end = c;
        end_e  = c;
        rej_m  = 1'b0;
        rdy_m  = 1'b1;
        pv     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        s         = '0;
        g1        = 1'b0;
        g2a       = 1'b0;
        g2b       = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("init_f", {24'b0, f}, 32'h0000_00FF);
        rst_n = 1'b1;
        #1;
        check("init_ready", {31'b0, req_ready}, 32'd1);
        check("init_busy", {31'b0, busy}, 32'd0);

        // Single enabled strobe on output 5
        cycle(1, 3'd5, 1, 0, 0);
        check("t2_f_first", {24'b0, f}, 32'h0000_00DF);
        for (int i = 0; i < 4; i++) cycle(0, 3'd0, 0, 0, 0);

        // Enables not met: rejected pulse, no strobe
        cycle(1, 3'd2, 1, 1, 0);
        check("t3_rejected", {31'b0, rejected}, 32'd1);
        cycle(0, 3'd0, 0, 0, 0);

        // Select/enable changes mid-pulse are ignored
        cycle(1, 3'd3, 1, 0, 0);
        check("t4_f_hold", {24'b0, f}, 32'h0000_00F7);
        cycle(0, 3'd6, 0, 0, 0);
        check("t4_f_hold2", {24'b0, f}, 32'h0000_00F7);
        for (int i = 0; i < 3; i++) cycle(0, 3'd6, 0, 0, 0);

        // Reset during a pulse with the request held valid
        cycle(1, 3'd3, 1, 0, 0);
        do_reset();
        cycle(1, 3'd3, 1, 0, 0);
        check("t5_reaccept", {24'b0, f}, 32'h0000_00F7);
        for (int i = 0; i < 4; i++) cycle(0, 3'd0, 0, 0, 0);

        // Back-to-back requests s=0 then s=7 held until accepted
        cycle(1, 3'd0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 3'd7, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 3'd0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            if (n % 400 == 399) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 9) < 6),
                      3'($urandom_range(0, 7)),
                      ($urandom_range(0, 9) < 8),
                      ($urandom_range(0, 9) < 2),
                      ($urandom_range(0, 9) < 2));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
